// File: rtl/btn_step_debounce_pkg.sv
// Shared constants for the push-button step conditioner: FSM encoding and
// default debounce timing for a 50 MHz board clock.
package btn_step_debounce_pkg;

  localparam int unsigned STABLE_CYCLES_50MHZ = 1_000_000;
  localparam int unsigned CNT_W_DEFAULT       = 20;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DROP = 2'd2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_step_debounce.sv
// Push-button conditioner: synchronise, debounce with a stable-time counter,
// emit press/release pulses and a held step request with a req/ack handshake.
module btn_step_debounce
  import btn_step_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_50MHZ,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic       clk_signal,
  input  logic       reset,
  input  logic       btn,
  input  logic       step_ack,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       step_req,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_s;
  logic             ack_s;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state_q;
  logic [1:0]       state_d;

  sync_2ff u_sync_btn (
    .clk   (clk_signal),
    .rst_n (reset),
    .d     (btn),
    .q     (btn_s)
  );

  sync_2ff u_sync_ack (
    .clk   (clk_signal),
    .rst_n (reset),
    .d     (step_ack),
    .q     (ack_s)
  );

  // Any sample matching the current level restarts the stable-time count;
  // the count stops at CNT_LAST where the level flips, so it never wraps.
  always_ff @(posedge clk_signal or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (btn_s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt           <= '0;
        btn_level     <= ~btn_level;
        press_pulse   <= ~btn_level;
        release_pulse <= btn_level;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Four-phase handshake: step_req rises on an accepted press and holds until
  // ack_s is seen high; the FSM then waits for ack_s low before it can issue
  // another request. Presses arriving outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (press_pulse) state_d = ST_REQ;
      ST_REQ:       if (ack_s)       state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!ack_s)      state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_signal or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      step_req <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_req <= (state_d == ST_REQ);
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_btn_step_debounce.sv
// Directed and randomized bench for btn_step_debounce with STABLE_CYCLES = 8,
// compared every cycle against a sample-window reference model.
module tb_btn_step_debounce;

  localparam int unsigned STABLE = 8;
  localparam int          LAT    = 10;

  logic       clk_signal = 1'b0;
  logic       reset      = 1'b0;
  logic       btn        = 1'b0;
  logic       step_ack   = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       step_req;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  btn_step_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .clk_signal    (clk_signal),
    .reset         (reset),
    .btn           (btn),
    .step_ack      (step_ack),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .step_req      (step_req),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk_signal = ~clk_signal;

  // ---------------- reference model ----------------
  // bh holds the raw button as seen at the last nine edges (bh[8] newest);
  // the synchronised sample used at an edge is the raw value two edges back,
  // so a level change needs bh[0..7] to all differ from the current level.
  logic       bh [0:8] = '{default: 1'b0};
  logic       ah [0:1] = '{default: 1'b0};
  logic       m_level = 1'b0;
  logic       m_press = 1'b0;
  logic       m_rel   = 1'b0;
  logic       m_req   = 1'b0;
  logic [1:0] m_phase = 2'd0;

  always @(posedge clk_signal or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) bh[i] = 1'b0;
      ah[0] = 1'b0; ah[1] = 1'b0;
      m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
      m_req = 1'b0; m_phase = 2'd0;
    end else begin
      bit all_diff;
      case (m_phase)
        2'd0: if (m_press) m_phase = 2'd1;
        2'd1: if (ah[0])   m_phase = 2'd2;
        default: if (!ah[0]) m_phase = 2'd0;
      endcase
      m_req = (m_phase == 2'd1);
      ah[0] = ah[1];
      ah[1] = step_ack;
      all_diff = 1'b1;
      for (int i = 0; i < 8; i++) if (bh[i] == m_level) all_diff = 1'b0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        m_press = m_level;
        m_rel   = ~m_level;
      end
      for (int i = 0; i < 8; i++) bh[i] = bh[i+1];
      bh[8] = btn;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int n_press = 0, n_rel = 0, n_req_rise = 0;
  logic req_prev = 1'b0;

  always @(negedge clk_signal) begin
    #2;
    check("level",   btn_level,     m_level);
    check("press",   press_pulse,   m_press);
    check("release", release_pulse, m_rel);
    check("req",     step_req,      m_req);
    check("state",   fsm_state,     m_phase);
    check("excl",    press_pulse & release_pulse, 0);
    if (press_pulse)            n_press++;
    if (release_pulse)          n_rel++;
    if (step_req && !req_prev)  n_req_rise++;
    req_prev = step_req;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_signal);
  endtask

  task automatic wait_pulse(input bit want_press, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_signal);
      cyc++;
    end while (!(want_press ? press_pulse : release_pulse) && cyc < 40);
  endtask

  task automatic handshake();
    step_ack = 1'b1;
    step(2);
    check("hs_req_held", step_req, 1);
    step(1);
    check("hs_req_drop", step_req, 0);
    check("hs_wait_drop", fsm_state, 2);
    step_ack = 1'b0;
    step(2);
    check("hs_still_wait", fsm_state, 2);
    step(1);
    check("hs_idle", fsm_state, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc, p0, r0, q0, run_b, run_a;

    step(1);
    #1;
    check("rst_level", btn_level, 0);
    check("rst_req",   step_req,  0);
    check("rst_state", fsm_state, 0);
    step(2);
    reset = 1'b1;
    step(3);

    // clean press
    p0 = n_press;
    btn = 1'b1;
    wait_pulse(1'b1, cyc);
    check("press_lat", cyc, LAT);
    check("press_level", btn_level, 1);
    check("req_not_yet", step_req, 0);
    step(1);
    check("req_next", step_req, 1);
    step(10);
    check("press_once", n_press - p0, 1);

    // clean release while a request is pending
    btn = 1'b0;
    wait_pulse(1'b0, cyc);
    check("release_lat", cyc, LAT);
    check("release_level", btn_level, 0);
    check("release_req_kept", step_req, 1);
    step(2);
    handshake();

    // second press serviced after a completed handshake
    btn = 1'b1;
    wait_pulse(1'b1, cyc);
    check("press2_lat", cyc, LAT);
    step(1);
    check("press2_req", step_req, 1);
    handshake();
    btn = 1'b0;
    wait_pulse(1'b0, cyc);
    step(3);

    // bounce: toggles every 3 cycles, then settles high
    p0 = n_press;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      step(3);
    end
    check("bounce_quiet", n_press - p0, 0);
    btn = 1'b1;
    wait_pulse(1'b1, cyc);
    check("bounce_lat", cyc, LAT);
    step(1);
    check("bounce_one", n_press - p0, 1);
    handshake();
    btn = 1'b0;
    wait_pulse(1'b0, cyc);
    step(3);

    // dropped press: second press while the first is still unacknowledged
    p0 = n_press; r0 = n_rel; q0 = n_req_rise;
    btn = 1'b1;
    wait_pulse(1'b1, cyc);
    btn = 1'b0;
    wait_pulse(1'b0, cyc);
    btn = 1'b1;
    wait_pulse(1'b1, cyc);
    step(2);
    check("drop_req_held", step_req, 1);
    check("drop_presses", n_press - p0, 2);
    check("drop_releases", n_rel - r0, 1);
    check("drop_req_once", n_req_rise - q0, 1);

    // reset mid-count (release counter at 5) with step_req high
    btn = 1'b0;
    step(7);
    btn = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_press", press_pulse, 0);
    check("mid_rst_rel",   release_pulse, 0);
    check("mid_rst_req",   step_req, 0);
    check("mid_rst_state", fsm_state, 0);
    step(2);
    reset = 1'b1;
    wait_pulse(1'b1, cyc);
    check("rst_repress_lat", cyc, LAT);
    step(1);
    check("rst_repress_req", step_req, 1);
    handshake();
    btn = 1'b0;
    wait_pulse(1'b0, cyc);

    // randomized runs on btn and step_ack, checked every cycle by the model
    run_b = 0;
    run_a = 0;
    for (int i = 0; i < 600; i++) begin
      if (run_b == 0) begin
        btn   = ($urandom_range(0, 3) != 0) ? ~btn : btn;
        run_b = $urandom_range(1, 14);
      end
      if (run_a == 0) begin
        step_ack = ~step_ack;
        run_a    = $urandom_range(1, 20);
      end
      run_b--;
      run_a--;
      step(1);
    end
    btn = 1'b0;
    step_ack = 1'b0;
    step(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_step_debounce.md
# btn_step_debounce

Front-end conditioner for the board push-button (`btn`). It synchronises the raw pad into the `clk_signal` domain and debounces it with a stable-time counter. It emits a single-cycle press pulse and a held step request that the CPU, running on the divided `clk`, consumes through a req/ack handshake. The block sits between the `btn` pad and the CPU single-step input inside the top-level wrapper.

## Interface
- `STABLE_CYCLES`, 1_000_000: consecutive identical synchronised samples needed to accept a level change (20 ms at 50 MHz).
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W > STABLE_CYCLES.
- `clk_signal`  in  1  50 MHz board clock; the only clock of this block.
- `reset`  in  1  asynchronous, active-low reset.
- `btn`  in  1  raw, bouncing, asynchronous push-button pad (1 = pressed).
- `step_ack`  in  1  acknowledge from the consumer in the divided-clock domain; treated as asynchronous.
- `btn_level`  out  1  debounced button level.
- `press_pulse`  out  1  one `clk_signal` cycle high per accepted press.
- `release_pulse`  out  1  one `clk_signal` cycle high per accepted release.
- `step_req`  out  1  step request, held until handshake completes.

## Operation
- Synchronisers:
  - `btn` passes through two flops to give `btn_s`.
  - `step_ack` passes through two flops to give `ack_s`.
  - Both synchroniser chains reset to 0.
- Debounce counter:
  - Clears whenever `btn_s` == `btn_level`.
  - Otherwise increments by 1 per cycle.
  - On reaching STABLE_CYCLES-1 while `btn_s` still differs from `btn_level`: toggle `btn_level`, clear the counter, raise the matching pulse for one cycle.
  - Any bounce (sample equal to `btn_level`) restarts the count from 0.
  - The counter never wraps; it is bounded by STABLE_CYCLES-1.
- Handshake FSM, states IDLE, REQ, WAIT_DROP:
  - IDLE → REQ on `press_pulse`; `step_req` = 1 in REQ.
  - REQ → WAIT_DROP when `ack_s` = 1; `step_req` = 0 from this transition onward.
  - WAIT_DROP → IDLE when `ack_s` = 0.
  - Presses accepted in REQ or WAIT_DROP are dropped, not queued. Exactly one step is issued per handshake.
- Reset values (asynchronous, on `reset` low): `btn_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `step_req` = 0, counter = 0, FSM = IDLE.
- Reset asserted mid-count or mid-handshake abandons all state immediately. After release, a still-pressed button is re-debounced and produces a fresh press.

## Timing
- Press latency, from `btn` rising (clean) to `press_pulse`: 2 synchroniser cycles + STABLE_CYCLES cycles.
- `btn_level` changes in the same cycle `press_pulse`/`release_pulse` is high.
- `step_req` rises on the cycle after `press_pulse`.
- Ack path: `step_req` falls 3 cycles after `step_ack` rises (2 synchroniser cycles + 1 FSM cycle).
- FSM returns to IDLE 3 cycles after `step_ack` falls.
- `press_pulse` and `release_pulse` are never high together; the minimum spacing between them is STABLE_CYCLES cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds the FSM state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT_DROP = 2'd2) and the default STABLE_CYCLES constant for 50 MHz.
- One sub-module, `sync_2ff`, a two-flop synchroniser with active-low async reset. It is instantiated twice, for `btn` and `step_ack`.
- The counter and FSM live in the top of this block.

## Test plan
All scenarios run with STABLE_CYCLES = 8 and CNT_W = 4.
- Clean press: `btn` 0→1, held 20 cycles → `press_pulse` high exactly once, 10 cycles after the edge; `btn_level` = 1; `step_req` = 1 on the next cycle.
- Bounce: `btn` toggles every 3 cycles for 30 cycles, then settles at 1 → no pulse during the bounce; one `press_pulse` 10 cycles after the last edge.
- Handshake: with `step_req` = 1, drive `step_ack` = 1:
  - `step_req` = 0 three cycles later.
  - Release `step_ack` → FSM back in IDLE 3 cycles later.
  - A second press is then serviced.
- Dropped press: press, release, press again while `step_ack` is still low → exactly one `step_req` assertion; two `press_pulse`s and one `release_pulse` are observed.
- Reset mid-operation: assert `reset` low at counter = 5 with `step_req` = 1 → all outputs are 0 in the same cycle. Deassert with `btn` held at 1 → new `press_pulse` 10 cycles later.
- Release: after an accepted press, `btn` 1→0 clean → `release_pulse` once after 10 cycles; `btn_level` = 0; `step_req` is unaffected.
